// File: rtl/bp_pkg.sv
// bp_pkg: shared definitions for the branch predictor slice.
//   - 2-bit saturating counter type and its encoding (SNT/WNT/WT/ST)
//   - predictor FSM state type (INIT sweep / RUN)
//   - default table depth and PC width
package bp_pkg;

  localparam int BP_ENTRIES = 16;
  localparam int BP_XLEN    = 32;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_t;

endpackage

// File: rtl/sat_counter2.sv
// sat_counter2: combinational next value of a 2-bit saturating counter.
// Ports:
//   ctr      in  current counter value
//   taken    in  resolved outcome (1 = count up, 0 = count down)
//   ctr_next out counter after one step, clamped at SNT and ST
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  // Step toward the outcome, holding at either end of the range.
  always_comb begin
    ctr_next = ctr;
    if (taken && (ctr != ST)) begin
      ctr_next = ctr + 2'd1;
    end else if (!taken && (ctr != SNT)) begin
      ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch history/target table.
// Fetch looks up fetch_pc combinationally; execute trains the table with
// resolved conditional branches. After reset or flush, an INIT sweep clears
// one valid bit per cycle before the table is used again.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 invalidate the whole table (single-cycle pulse)
//   fetch_pc              PC being fetched
//   pred_taken            predict taken
//   pred_target           predicted next PC
//   ready                 table usable (RUN state)
//   upd_valid             a resolved conditional branch this cycle
//   upd_pc                PC of the resolved branch
//   upd_taken             actual outcome
//   upd_target            computed branch target
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int XLEN    = BP_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            ready,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  bp_state_t          state_q, state_d;
  logic [IDX-1:0]     clr_idx_q, clr_idx_d;
  logic [ENTRIES-1:0] valid_q;

  logic [TAGW-1:0]    tag_q    [ENTRIES];
  ctr_t               ctr_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];

  logic [IDX-1:0]     fetch_idx, upd_idx;
  logic [TAGW-1:0]    fetch_tag, upd_tag;
  logic               fetch_hit, upd_hit;
  logic               train_en, do_train_hit, do_alloc;
  ctr_t               upd_ctr_next;

  // The low two PC bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign fetch_idx = fetch_pc[IDX+1:2];
  assign fetch_tag = fetch_pc[XLEN-1:IDX+2];
  assign upd_idx   = upd_pc[IDX+1:2];
  assign upd_tag   = upd_pc[XLEN-1:IDX+2];

  // Lookup reads registered contents only, so a same-cycle update to the
  // same entry is not forwarded.
  assign ready       = (state_q == RUN);
  assign fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign pred_taken  = ready && fetch_hit && ctr_q[fetch_idx][1];
  assign pred_target = pred_taken ? target_q[fetch_idx] : fetch_pc + XLEN'(4);

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  sat_counter2 u_sat_counter2 (
    .ctr      (ctr_q[upd_idx]),
    .taken    (upd_taken),
    .ctr_next (upd_ctr_next)
  );

  // Training only happens in RUN; a flush in the same cycle drops the update.
  assign train_en     = ready && upd_valid && !flush;
  assign do_train_hit = train_en && upd_hit;
  assign do_alloc     = train_en && !upd_hit && upd_taken;

  // INIT walks clr_idx across the table once, then hands over to RUN.
  // Flush is only honoured from RUN, so a flush mid-sweep cannot restart it.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      INIT: begin
        if (clr_idx_q == IDX'(ENTRIES - 1)) begin
          state_d   = RUN;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + IDX'(1);
        end
      end
      RUN: begin
        if (flush) begin
          state_d   = INIT;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = INIT;
        clr_idx_d = '0;
      end
    endcase
  end

  // Control state and valid bits; the sweep clears one valid bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      clr_idx_q <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      if (state_q == INIT) begin
        valid_q[clr_idx_q] <= 1'b0;
      end else if (do_alloc) begin
        valid_q[upd_idx] <= 1'b1;
      end
    end
  end

  // Payload arrays carry no reset so they can map onto RAM; a new entry
  // starts weakly taken since it was allocated on a taken branch.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      tag_q[upd_idx]    <= upd_tag;
      ctr_q[upd_idx]    <= WT;
      target_q[upd_idx] <= upd_target;
    end else if (do_train_hit) begin
      ctr_q[upd_idx] <= upd_ctr_next;
      if (upd_taken) begin
        target_q[upd_idx] <= upd_target;
      end
    end
  end

endmodule
